// File: rtl/led_cmd_ctrl_pkg.sv
// Shared PS/2 keyboard command constants and the LED controller state encoding.
package led_cmd_ctrl_pkg;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_SEND_CMD     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK_CMD = 3'd2;
    localparam logic [2:0] ST_SEND_LED     = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK_LED = 3'd4;

    // Only caps-lock is driven; scroll-lock (bit 0) and num-lock (bit 1) stay off.
    function automatic logic [7:0] led_byte(input logic caps);
        return {5'b0, caps, 2'b00};
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Saturating reply timer: counts while enabled, flags the last cycle of the window.
module timeout_counter #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic i_sclr,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (i_sclr || i_clr) begin
            count <= '0;
        end else if (i_en && count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign o_expired = i_en && (count == LAST);

endmodule

// File: rtl/led_cmd_ctrl.sv
// Keyboard LED updater: sends 0xED + LED byte to the keyboard whenever caps-lock
// changes, with ack/resend/timeout handling and a bounded number of retries.
module led_cmd_ctrl
    import led_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT   = 1_000_000,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_capslock,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte,
    output logic       o_tx_req,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    output logic       o_rx_filter,
    output logic       o_busy,
    output logic       o_error
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    logic [2:0]    state;
    logic          caps_lat;
    logic          caps_q;
    logic          pending;
    logic [RW-1:0] retry;
    logic          in_wait;
    logic          expired;
    logic          ack;
    logic          nack;
    logic          last_try;

    assign in_wait     = (state == ST_WAIT_ACK_CMD) || (state == ST_WAIT_ACK_LED);
    assign o_rx_filter = in_wait;
    assign o_busy      = (state != ST_IDLE);
    assign ack         = i_byte_en && (i_byte == PS2_ACK);
    assign nack        = (i_byte_en && (i_byte == PS2_RESEND)) || expired;
    assign last_try    = (int'(retry) + 1 >= MAX_RETRY);

    // Timer is held clear outside the reply windows, so every wait starts from zero.
    timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .i_sclr    (i_sclr),
        .i_en      (in_wait),
        .i_clr     (!in_wait),
        .o_expired (expired)
    );

    always_ff @(posedge clk) begin
        caps_q <= i_capslock;
        if (i_sclr) begin
            state     <= ST_IDLE;
            caps_lat  <= 1'b0;
            pending   <= 1'b0;
            retry     <= '0;
            o_tx_req  <= 1'b0;
            o_tx_byte <= 8'h00;
            o_error   <= 1'b0;
        end else begin
            o_tx_req <= 1'b0;
            // Edges during a sequence collapse into a single relaunch from IDLE.
            if (state != ST_IDLE && i_capslock != caps_q) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_capslock != caps_lat || pending) begin
                        caps_lat  <= i_capslock;
                        pending   <= 1'b0;
                        state     <= ST_SEND_CMD;
                        o_tx_req  <= 1'b1;
                        o_tx_byte <= PS2_CMD_SET_LED;
                    end
                end
                ST_SEND_CMD: begin
                    if (i_tx_done) state <= ST_WAIT_ACK_CMD;
                end
                ST_SEND_LED: begin
                    if (i_tx_done) state <= ST_WAIT_ACK_LED;
                end
                ST_WAIT_ACK_CMD, ST_WAIT_ACK_LED: begin
                    if (ack) begin
                        retry <= '0;
                        if (state == ST_WAIT_ACK_CMD) begin
                            state     <= ST_SEND_LED;
                            o_tx_req  <= 1'b1;
                            o_tx_byte <= led_byte(caps_lat);
                        end else begin
                            state   <= ST_IDLE;
                            o_error <= 1'b0;
                        end
                    end else if (nack) begin
                        if (last_try) begin
                            // Give up; caps_lat is kept so IDLE does not relaunch on its own.
                            retry   <= '0;
                            o_error <= 1'b1;
                            pending <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            retry    <= retry + RW'(1);
                            o_tx_req <= 1'b1;
                            state    <= (state == ST_WAIT_ACK_CMD) ? ST_SEND_CMD : ST_SEND_LED;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Bench for led_cmd_ctrl: acts as PS/2 transmitter and keyboard, predicts the
// transmitted byte stream and final error flag from ack/resend/timeout replies.
module tb_led_cmd_ctrl;

    localparam int TIMEOUT   = 16;
    localparam int MAX_RETRY = 3;

    logic       clk = 1'b0;
    logic       i_sclr = 1'b1;
    logic       i_capslock = 1'b0;
    logic       i_byte_en = 1'b0;
    logic [7:0] i_byte = 8'h00;
    logic       i_tx_done = 1'b0;
    logic       o_tx_req;
    logic [7:0] o_tx_byte;
    logic       o_rx_filter;
    logic       o_busy;
    logic       o_error;

    int         checks = 0;
    int         passes = 0;
    int         req_cnt = 0;
    logic [7:0] req_byte = 8'h00;

    // Reply plan codes: 0 ack, 1 resend, 2 junk scancode then ack, 3 silence.
    int         plan[$];
    int         done_delay = -1;
    bit         rnd = 1'b0;
    bit         toggle_led = 1'b0;

    always #5 clk = ~clk;

    led_cmd_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_capslock  (i_capslock),
        .i_byte_en   (i_byte_en),
        .i_byte      (i_byte),
        .o_tx_req    (o_tx_req),
        .o_tx_byte   (o_tx_byte),
        .i_tx_done   (i_tx_done),
        .o_rx_filter (o_rx_filter),
        .o_busy      (o_busy),
        .o_error     (o_error)
    );

    always @(negedge clk) begin
        if (o_tx_req === 1'b1) begin
            req_cnt++;
            req_byte = o_tx_byte;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        i_byte    = b;
        i_byte_en = 1'b1;
        @(negedge clk);
        i_byte_en = 1'b0;
    endtask

    task automatic wait_req(input int base, output bit ok);
        int n = 0;
        while (req_cnt == base && n < 200) begin
            @(posedge clk);
            n++;
        end
        ok = (req_cnt != base);
    endtask

    // Serves one whole LED sequence; expectations come from counting attempts per byte.
    task automatic serve_seq(input logic [7:0] led, input string name, output bit err_exp);
        int phase = 0;
        int tries = 0;
        int attempts = 0;
        int code;
        int dly;
        int n;
        int base0;
        bit ok;
        logic [7:0] exp_b;
        base0   = req_cnt;
        err_exp = 1'b0;
        forever begin
            exp_b = (phase == 0) ? 8'hED : led;
            wait_req(base0 + attempts, ok);
            checks++;
            if (!ok) begin
                $display("FAIL %s req_timeout: got %0d requests, required %0d", name, req_cnt - base0, attempts + 1);
                break;
            end
            passes++;
            attempts++;
            checks++;
            if (req_byte !== exp_b) $display("FAIL %s tx_byte: got %02h, required %02h", name, req_byte, exp_b);
            else passes++;
            dly = (done_delay >= 0) ? done_delay : int'($urandom_range(0, 12));
            repeat (dly + 1) @(negedge clk);
            checks++;
            if (o_tx_byte !== exp_b || o_rx_filter !== 1'b0)
                $display("FAIL %s hold: tx_byte %02h filter %b, required %02h filter 0", name, o_tx_byte, o_rx_filter, exp_b);
            else passes++;
            i_tx_done = 1'b1;
            @(negedge clk);
            i_tx_done = 1'b0;
            checks++;
            if (o_rx_filter !== 1'b1) $display("FAIL %s rx_filter: got %b, required 1", name, o_rx_filter);
            else passes++;
            if (phase == 1 && toggle_led) begin
                i_capslock = ~i_capslock;
                @(negedge clk);
                i_capslock = ~i_capslock;
                @(negedge clk);
                toggle_led = 1'b0;
            end
            if (plan.size() > 0) code = plan.pop_front();
            else if (rnd) begin
                n = int'($urandom_range(0, 9));
                code = (n < 6) ? 0 : (n < 8) ? 1 : (n == 8) ? 2 : 3;
            end else code = 0;
            case (code)
                0: begin send_byte(8'hFA); phase++; tries = 0; end
                1: begin send_byte(8'hFE); tries++; end
                2: begin
                    send_byte(8'h1C);
                    checks++;
                    if (o_rx_filter !== 1'b1 || o_busy !== 1'b1 || req_cnt != base0 + attempts)
                        $display("FAIL %s junk: filter %b busy %b reqs %0d, required 1 1 %0d",
                                 name, o_rx_filter, o_busy, req_cnt - base0, attempts);
                    else passes++;
                    send_byte(8'hFA);
                    phase++;
                    tries = 0;
                end
                default: tries++;
            endcase
            if (phase == 2) break;
            if (tries == MAX_RETRY) begin
                err_exp = 1'b1;
                break;
            end
        end
        n = 0;
        while (o_busy !== 1'b0 && n < 4 * TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (o_busy !== 1'b0) $display("FAIL %s busy_end: got %b, required 0", name, o_busy);
        else passes++;
        checks++;
        if (o_error !== err_exp) $display("FAIL %s error: got %b, required %b", name, o_error, err_exp);
        else passes++;
        checks++;
        if (req_cnt != base0 + attempts)
            $display("FAIL %s req_count: got %0d, required %0d", name, req_cnt - base0, attempts);
        else passes++;
    endtask

    task automatic test_reset();
        i_sclr = 1'b1;
        i_capslock = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_tx_req, o_rx_filter, o_busy, o_error} !== 4'b0000 || o_tx_byte !== 8'h00)
            $display("FAIL reset_outputs: req %b filt %b busy %b err %b byte %02h, required all 0",
                     o_tx_req, o_rx_filter, o_busy, o_error, o_tx_byte);
        else passes++;
        i_sclr = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (req_cnt != 0 || o_busy !== 1'b0)
            $display("FAIL reset_idle: reqs %0d busy %b, required 0 0", req_cnt, o_busy);
        else passes++;
    endtask

    task automatic test_basic();
        bit e;
        done_delay = 10;
        plan = '{0, 0};
        i_capslock = 1'b1;
        serve_seq(8'h04, "basic", e);
        done_delay = -1;
    endtask

    task automatic test_resend();
        bit e;
        plan = '{1, 0, 0};
        i_capslock = 1'b0;
        serve_seq(8'h00, "resend", e);
    endtask

    task automatic test_junk();
        bit e;
        plan = '{2, 0};
        i_capslock = 1'b1;
        serve_seq(8'h04, "junk", e);
    endtask

    task automatic test_timeout();
        bit e;
        int base;
        plan = '{3, 3, 3};
        i_capslock = 1'b0;
        serve_seq(8'h00, "timeout", e);
        base = req_cnt;
        repeat (5) @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (req_cnt != base || o_busy !== 1'b0 || o_error !== 1'b1)
            $display("FAIL timeout_no_relaunch: reqs %0d busy %b err %b, required 0 0 1", req_cnt - base, o_busy, o_error);
        else passes++;
        plan = '{0, 0};
        i_capslock = 1'b1;
        serve_seq(8'h04, "error_clear", e);
    endtask

    task automatic test_pending();
        bit e;
        int base;
        i_capslock = 1'b0;
        serve_seq(8'h00, "pending_pre", e);
        toggle_led = 1'b1;
        i_capslock = 1'b1;
        serve_seq(8'h04, "pending_first", e);
        serve_seq(8'h04, "pending_relaunch", e);
        base = req_cnt;
        repeat (40) @(negedge clk);
        checks++;
        if (req_cnt != base || o_busy !== 1'b0)
            $display("FAIL pending_single: extra reqs %0d busy %b, required 0 0", req_cnt - base, o_busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        bit e;
        bit ok;
        int base;
        i_capslock = 1'b0;
        serve_seq(8'h00, "resetmid_pre", e);
        base = req_cnt;
        i_capslock = 1'b1;
        wait_req(base, ok);
        checks++;
        if (!ok || req_byte !== 8'hED) $display("FAIL resetmid_cmd: seen %b byte %02h, required 1 ed", ok, req_byte);
        else passes++;
        @(negedge clk);
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        send_byte(8'hFA);
        wait_req(base + 1, ok);
        checks++;
        if (!ok || req_byte !== 8'h04) $display("FAIL resetmid_led: seen %b byte %02h, required 1 04", ok, req_byte);
        else passes++;
        @(negedge clk);
        i_sclr = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_tx_req, o_rx_filter, o_busy, o_error} !== 4'b0000 || o_tx_byte !== 8'h00 || req_cnt != base + 2)
            $display("FAIL resetmid_outputs: req %b filt %b busy %b err %b byte %02h reqs %0d, required all 0 reqs 2",
                     o_tx_req, o_rx_filter, o_busy, o_error, o_tx_byte, req_cnt - base);
        else passes++;
        i_sclr = 1'b0;
        serve_seq(8'h04, "resetmid_restart", e);
    endtask

    task automatic test_random();
        bit e;
        rnd = 1'b1;
        done_delay = -1;
        for (int i = 0; i < 20; i++) begin
            i_capslock = ~i_capslock;
            serve_seq({5'b0, i_capslock, 2'b00}, "random", e);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end
        rnd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resend();
        test_junk();
        test_timeout();
        test_pending();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
